// File: rtl/delay_seq_pkg.sv
// Shared types for the multi-channel delay sequencer.
package delay_seq_pkg;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

   typedef enum logic {ModeCascade = 1'b0, ModeParallel = 1'b1} mode_t;

   // Channel index width; a single channel still needs one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dly_counter.sv
// Clear/enable saturating up-counter with equality compare against cmp_i.
module dly_counter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] cmp_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             match_o
);

   localparam logic [CNT_W-1:0] CntMax = '1;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != CntMax)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o   = cnt_q;
   assign match_o = (cnt_q == cmp_i);

endmodule

// File: rtl/delay_seq_gen.sv
// Multi-channel programmable delay sequencer, cascaded or parallel release.
// Optional power-on implicit start: define DELAY_SEQ_GEN_AUTOSTART_EN.
module delay_seq_gen
   import delay_seq_pkg::*;
#(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CNT_W  = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start_i,
   input  logic                    mode_i,
   input  logic [NUM_CH*CNT_W-1:0] dly_i,
   output logic [NUM_CH-1:0]       out_o,
   output logic                    busy_o,
   output logic                    done_o
);

   localparam int unsigned     IdxW    = idx_width(NUM_CH);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_CH - 1);

   state_t                        state_q, state_d;
   mode_t                         mode_q, mode_d;
   logic [NUM_CH-1:0][CNT_W-1:0]  dly_q, dly_d;
   logic [IdxW-1:0]               idx_q, idx_d;
   logic [NUM_CH-1:0]             out_q, out_d;
   logic                          busy_q, busy_d;
   logic                          done_q, done_d;

   logic                          start_eff;
   logic                          cnt_clr, cnt_en, cnt_match;
   logic [CNT_W-1:0]              cnt;
   logic [NUM_CH-1:0]             hit;

`ifdef DELAY_SEQ_GEN_AUTOSTART_EN
   // High only for the first edge after reset release.
   logic auto_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         auto_q <= 1'b1;
      end else begin
         auto_q <= 1'b0;
      end
   end

   assign start_eff = start_i | auto_q;
`else
   assign start_eff = start_i;
`endif

   dly_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (cnt_clr),
      .en_i    (cnt_en),
      .cmp_i   (dly_q[idx_q]),
      .cnt_o   (cnt),
      .match_o (cnt_match)
   );

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      dly_d   = dly_q;
      idx_d   = idx_q;
      out_d   = out_q;
      busy_d  = busy_q;
      done_d  = done_q;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      hit     = '0;

      if (start_eff) begin
         // Start wins in every state: aborts a run or re-arms after done.
         state_d = StRun;
         mode_d  = mode_t'(mode_i);
         dly_d   = dly_i;
         idx_d   = '0;
         out_d   = '0;
         busy_d  = 1'b1;
         done_d  = 1'b0;
         cnt_clr = 1'b1;
      end else if (state_q == StRun) begin
         cnt_en = 1'b1;
         if (mode_q == ModeCascade) begin
            if (cnt_match) begin
               out_d[idx_q] = 1'b1;
               cnt_clr      = 1'b1;
               if (idx_q == LastIdx) begin
                  state_d = StDone;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + IdxW'(1);
               end
            end
         end else begin
            for (int k = 0; k < NUM_CH; k++) begin
               hit[k] = (cnt == dly_q[k]);
            end
            out_d = out_q | hit;
            if (&out_d) begin
               state_d = StDone;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         mode_q  <= ModeCascade;
         dly_q   <= '0;
         idx_q   <= '0;
         out_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         dly_q   <= dly_d;
         idx_q   <= idx_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign out_o  = out_q;
   assign busy_o = busy_q;
   assign done_o = done_q;

endmodule

// File: tb/tb_delay_seq_gen.sv
// Scoreboard bench for delay_seq_gen (4 channels, 8-bit delays).
module tb_delay_seq_gen;

   logic        clk;
   logic        rst;
   logic        start_i;
   logic        mode_i;
   logic [31:0] dly_i;
   logic [3:0]  out_o;
   logic        busy_o;
   logic        done_o;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [3:0] out;
      logic       busy;
      logic       done;
   } exp_t;

   exp_t sb[$];

   delay_seq_gen #(
      .NUM_CH (4),
      .CNT_W  (8)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start_i (start_i),
      .mode_i  (mode_i),
      .dly_i   (dly_i),
      .out_o   (out_o),
      .busy_o  (busy_o),
      .done_o  (done_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Channel k rise time after E0: running sum (cascade) or own delay (parallel), plus one.
   task automatic push_model(input logic md, input logic [31:0] d, input int ncyc);
      int   rise[4];
      int   acc;
      int   last;
      exp_t e;
      acc  = 0;
      last = 0;
      for (int k = 0; k < 4; k++) begin
         if (md == 1'b0) begin
            acc     = acc + int'(d[k*8 +: 8]) + 1;
            rise[k] = acc;
         end else begin
            rise[k] = int'(d[k*8 +: 8]) + 1;
         end
         if (rise[k] > last) last = rise[k];
      end
      for (int t = 0; t <= ncyc; t++) begin
         for (int k = 0; k < 4; k++) e.out[k] = (t >= rise[k]);
         e.done = (t >= last);
         e.busy = !e.done;
         sb.push_back(e);
      end
   endtask

   task automatic drain(input string name);
      exp_t e;
      int   t;
      t = 0;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if ({out_o, busy_o, done_o} !== {e.out, e.busy, e.done}) begin
            errors++;
            $display("FAIL %s t=%0d: got out=%b busy=%b done=%b, expected out=%b busy=%b done=%b",
                     name, t, out_o, busy_o, done_o, e.out, e.busy, e.done);
         end
         if (sb.size() > 0) begin
            step();
            t++;
         end
      end
   endtask

   // Start edge, then scramble dly_i/mode_i to show they are ignored afterwards.
   task automatic launch(input logic md, input logic [31:0] d);
      start_i = 1'b1;
      mode_i  = md;
      dly_i   = d;
      step();
      start_i = 1'b0;
      mode_i  = ~md;
      dly_i   = $urandom;
   endtask

   task automatic test_reset();
      rst     = 1'b0;
      start_i = 1'b0;
      mode_i  = 1'b0;
      dly_i   = {8'd1, 8'd1, 8'd1, 8'd1};
      #12;
      checks++;
      if ({out_o, busy_o, done_o} !== 6'b0) begin
         errors++;
         $display("FAIL reset_state: got out=%b busy=%b done=%b, expected all 0",
                  out_o, busy_o, done_o);
      end
      #11;
      rst = 1'b1;
      step();
`ifdef DELAY_SEQ_GEN_AUTOSTART_EN
      push_model(1'b0, {8'd1, 8'd1, 8'd1, 8'd1}, 10);
      drain("autostart");
`else
      for (int i = 0; i < 12; i++) begin
         checks++;
         if ({out_o, busy_o, done_o} !== 6'b0) begin
            errors++;
            $display("FAIL idle_after_reset cyc=%0d: got out=%b busy=%b done=%b, expected all 0",
                     i, out_o, busy_o, done_o);
         end
         step();
      end
`endif
   endtask

   task automatic test_cascade();
      launch(1'b0, {8'd1, 8'd2, 8'd0, 8'd3});
      push_model(1'b0, {8'd1, 8'd2, 8'd0, 8'd3}, 13);
      drain("cascade");
   endtask

   task automatic test_parallel();
      launch(1'b1, {8'd0, 8'd5, 8'd1, 8'd5});
      push_model(1'b1, {8'd0, 8'd5, 8'd1, 8'd5}, 9);
      drain("parallel");
   endtask

   task automatic test_restart();
      launch(1'b0, {8'd1, 8'd2, 8'd0, 8'd3});
      push_model(1'b0, {8'd1, 8'd2, 8'd0, 8'd3}, 5);
      drain("restart_pre");
      launch(1'b0, {8'd1, 8'd2, 8'd0, 8'd3});
      push_model(1'b0, {8'd1, 8'd2, 8'd0, 8'd3}, 12);
      drain("restart_post");
   endtask

   task automatic test_start_held();
      start_i = 1'b1;
      mode_i  = 1'b0;
      dly_i   = '0;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if ({out_o, busy_o, done_o} !== {4'b0000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL start_held cyc=%0d: got out=%b busy=%b done=%b, expected 0000/1/0",
                     i, out_o, busy_o, done_o);
         end
      end
      start_i = 1'b0;
      push_model(1'b0, 32'd0, 6);
      drain("start_release");
   endtask

   task automatic test_saturation();
      launch(1'b1, {4{8'd255}});
      push_model(1'b1, {4{8'd255}}, 259);
      drain("saturation");
   endtask

   task automatic test_back_to_back();
      launch(1'b0, 32'd0);
      push_model(1'b0, 32'd0, 6);
      drain("b2b_cascade0");
      launch(1'b1, {8'd2, 8'd0, 8'd7, 8'd3});
      push_model(1'b1, {8'd2, 8'd0, 8'd7, 8'd3}, 10);
      drain("b2b_parallel");
   endtask

   task automatic test_reset_mid();
      launch(1'b0, 32'd0);
      push_model(1'b0, 32'd0, 2);
      drain("reset_mid_pre");
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({out_o, busy_o, done_o} !== 6'b0) begin
         errors++;
         $display("FAIL reset_mid_async: got out=%b busy=%b done=%b, expected all 0",
                  out_o, busy_o, done_o);
      end
      mode_i = 1'b0;
      dly_i  = '0;
      #3;
      rst = 1'b1;
      step();
`ifdef DELAY_SEQ_GEN_AUTOSTART_EN
      push_model(1'b0, 32'd0, 6);
      drain("reset_mid_autostart");
`else
      for (int i = 0; i < 6; i++) begin
         checks++;
         if ({out_o, busy_o, done_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_mid_idle cyc=%0d: got out=%b busy=%b done=%b, expected all 0",
                     i, out_o, busy_o, done_o);
         end
         step();
      end
`endif
   endtask

   initial begin
      test_reset();
      test_cascade();
      test_parallel();
      test_restart();
      test_start_held();
      test_saturation();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
